morse_sequencer: RTL
====================

MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 25000000, Clock cycles per Morse time unit (0.5 s at 50 MHz); legal range 2 or more.
REQ-002 Clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low; clock Clock.
REQ-004 letter  input  3  letter select, 0..7 = A..H.
REQ-005 start_n  input  1  active-low pushbutton level (KEY[1]), asynchronous to Clock.
REQ-006 led  output  1  Morse light; 1 = element on.
REQ-007 busy  output  1  high from LOAD until DONE inclusive.
REQ-008 done  output  1  one-cycle pulse when a letter has finished.

Function
REQ-009 start_n SHALL pass through a 2-flop synchronizer; a 1->0 transition of the synchronized level SHALL produce a one-cycle start pulse.
REQ-010 FSM states: IDLE, LOAD, ON, GAP, DONE; encoding from shared package.
REQ-011 IDLE: start pulse -> LOAD; otherwise stay.
REQ-012 LOAD (1 cycle): latch pattern[3:0] and size[2:0] from ROM via letter; clear element index and tick counter; -> ON.
REQ-013 Letter ROM (MSB first, 0 = dot, 1 = dash): A 0100/2, B 1000/4, C 1010/4, D 1000/3, E 0000/1, F 0010/4, G 1100/3, H 0000/4.
REQ-014 ON: led = 1; stay 1 tick for a dot, 3 ticks for a dash (current element = pattern[3]); -> GAP.
REQ-015 GAP: led = 0 for exactly 1 tick; on exit, shift pattern left 1 and increment element index; index == size -> DONE, else -> ON.
REQ-016 DONE (1 cycle): done = 1; -> IDLE.
REQ-017 Tick: counter 0..TICK_DIV-1 runs only in ON/GAP; tick asserted for the cycle where count == TICK_DIV-1, then wraps to 0; counter cleared in LOAD and on every state change so each unit is exactly TICK_DIV cycles.
REQ-018 led, busy, done SHALL be Moore decodes of the state register (no added latency).
REQ-019 Start pulses outside IDLE SHALL be ignored; letter changes after LOAD SHALL NOT affect the letter in progress.
REQ-020 Latency: led rises at the 4th rising edge after the first edge sampling start_n = 0 (sync 2, IDLE->LOAD, LOAD->ON).
REQ-021 Held start_n low SHALL start exactly one letter; a new letter needs release and re-press.
REQ-022 Element index is 3 bits and SHALL NOT wrap; size is always 1..4.

Reset
REQ-023 reset = 0 at a rising edge SHALL force IDLE, led = 0, busy = 0, done = 0, tick counter = 0, index = 0, pattern = 0, both synchronizer flops and the edge-detect flop = 1, including mid-letter.
REQ-024 First start accepted only after reset = 1 and a fresh 1->0 edge on start_n.

Structure
REQ-025 Package morse_pkg SHALL hold the state encoding, the letter ROM constants, and the dot/dash/gap unit counts (1/3/1).
REQ-026 Tick divider SHALL be sub-module morse_tick_gen (Clock, reset, clear, run -> tick), parameterised by TICK_DIV.

Verification (TICK_DIV = 4)
REQ-027 letter = E, press -> led high 4 cycles from edge 4, low 4 cycles, done pulse 1 cycle, busy high 10 cycles total.
REQ-028 letter = A -> led on 4, off 4, on 12, off 4, then done; total busy = 26 cycles.
REQ-029 letter = B, second press and letter = 7 during ON -> sequence unchanged (12, 4, then 4/4 x3), exactly one done.
REQ-030 letter = C, reset low for 1 cycle during 2nd element -> next cycle led = busy = done = 0, state IDLE; no done pulse appears afterwards.
REQ-031 start_n held low 100 cycles with letter = H -> exactly one H (four 4-cycle dots), one done; after release and re-press, second H runs.
REQ-032 start_n toggled for 1 cycle only -> still registered as one start (after 2-cycle sync delay); glitch-free led (no 1-cycle pulses).

Source files
------------

// File: rtl/morse_pkg.sv
// Shared encodings for the Morse letter sequencer: FSM states, element
// timing in Morse units, and the A..H letter ROM.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ON   = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int unsigned DOT_UNITS  = 1;
    localparam int unsigned DASH_UNITS = 3;
    localparam int unsigned GAP_UNITS  = 1;

    // pattern is MSB first, 1 = dash; size is the element count (1..4)
    typedef struct packed {
        logic [3:0] pattern;
        logic [2:0] size;
    } rom_entry_t;

    function automatic rom_entry_t letter_lookup(input logic [2:0] sel);
        rom_entry_t e;
        case (sel)
            3'd0:    e = '{pattern: 4'b0100, size: 3'd2}; // A .-
            3'd1:    e = '{pattern: 4'b1000, size: 3'd4}; // B -...
            3'd2:    e = '{pattern: 4'b1010, size: 3'd4}; // C -.-.
            3'd3:    e = '{pattern: 4'b1000, size: 3'd3}; // D -..
            3'd4:    e = '{pattern: 4'b0000, size: 3'd1}; // E .
            3'd5:    e = '{pattern: 4'b0010, size: 3'd4}; // F ..-.
            3'd6:    e = '{pattern: 4'b1100, size: 3'd3}; // G --.
            default: e = '{pattern: 4'b0000, size: 3'd4}; // H ....
        endcase
        return e;
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Morse time-unit divider: free-runs while enabled and pulses tick on the
// last cycle of each TICK_DIV-cycle unit.
module morse_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic Clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] r_count;

    assign tick = run && (r_count == W'(TICK_DIV - 1));

    always_ff @(posedge Clock) begin
        if (!reset)
            r_count <= '0;
        else if (clear)
            r_count <= '0;
        else if (run)
            r_count <= tick ? '0 : r_count + 1'b1;
    end

endmodule

// File: rtl/morse_sequencer.sv
// Plays one Morse letter (A..H) on led per start button press, with element
// and gap timing measured in TICK_DIV-cycle units.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int TICK_DIV = 25000000
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic [2:0] letter,
    input  logic       start_n,
    output logic       led,
    output logic       busy,
    output logic       done
);

    state_t     r_state, w_next;
    logic       r_sync1, r_sync2, r_prev;
    logic [3:0] r_pattern;
    logic [2:0] r_size;
    logic [2:0] r_index;
    logic [1:0] r_units;

    logic       w_start, w_tick, w_run, w_clear, w_unit_last, w_last_elem;
    logic [1:0] w_target;
    rom_entry_t w_rom;

    // Falling edge of the synchronized button level
    assign w_start = r_prev & ~r_sync2;
    assign w_rom   = letter_lookup(letter);

    assign w_target    = (r_state == ST_GAP) ? 2'(GAP_UNITS) :
                         (r_pattern[3] ? 2'(DASH_UNITS) : 2'(DOT_UNITS));
    assign w_unit_last = (r_units == w_target - 2'd1);
    assign w_last_elem = (r_index + 3'd1 == r_size);

    assign w_run   = (r_state == ST_ON) || (r_state == ST_GAP);
    // Restart the unit on every state change so each unit is full length
    assign w_clear = (r_state == ST_LOAD) || (w_next != r_state);

    morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .Clock (Clock),
        .reset (reset),
        .clear (w_clear),
        .run   (w_run),
        .tick  (w_tick)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next = ST_LOAD;
            ST_LOAD: w_next = ST_ON;
            ST_ON:   if (w_tick && w_unit_last) w_next = ST_GAP;
            ST_GAP:  if (w_tick && w_unit_last) w_next = w_last_elem ? ST_DONE : ST_ON;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_prev    <= 1'b1;
            r_pattern <= '0;
            r_size    <= '0;
            r_index   <= '0;
            r_units   <= '0;
        end else begin
            r_state <= w_next;
            r_sync1 <= start_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            case (r_state)
                ST_LOAD: begin
                    r_pattern <= w_rom.pattern;
                    r_size    <= w_rom.size;
                    r_index   <= '0;
                    r_units   <= '0;
                end
                ST_ON, ST_GAP: begin
                    if (w_tick) begin
                        r_units <= w_unit_last ? 2'd0 : r_units + 2'd1;
                        if (r_state == ST_GAP && w_unit_last) begin
                            r_pattern <= {r_pattern[2:0], 1'b0};
                            if (!w_last_elem)
                                r_index <= r_index + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign led  = (r_state == ST_ON);
    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

endmodule
